// File: rtl/scan_scheduler.sv
// ---------------------------------------------------------------------------
// scan_scheduler
//
// Purpose:
//   Walks the column pairs of one theta slice. For every column index taken
//   from the slice's enable mask it drives the paired frame-buffer addresses,
//   waits for the frame buffer's fixed read latency, captures the returned
//   column data and offers it to the LED panel driver over a valid/ready
//   handshake. A new theta strobe arriving mid-slice aborts the slice.
//
// Configuration macro:
//   SCANLINE_SKIP_EN - defined: only column pairs whose mask bit is set are
//                      visited. Undefined: col_mask_in is ignored and every
//                      index 0..SCAN_RATE-1 is visited in order.
//
// Ports:
//   clk_in          system clock
//   rst_n_in        asynchronous active-low reset
//   theta_in        angle of the slice being started
//   theta_valid_in  one-cycle strobe, a new slice begins
//   col_mask_in     per-index enable mask, sampled with theta_valid_in
//   col_num1_out    first column address to the frame buffer
//   col_num2_out    second column address (col_num1_out + SCAN_RATE)
//   columns_in      frame-buffer data for the addressed pair
//   columns_out     captured column data to the panel driver
//   col_idx_out     index belonging to columns_out
//   theta_out       latched theta of the slice in progress
//   valid_out       columns_out / col_idx_out valid
//   ready_in        panel driver accepts
//   busy_out        a slice is in progress
//   frame_done_out  pulse: last column accepted, or empty mask
//   overrun_out     pulse: slice aborted by a new theta strobe
// ---------------------------------------------------------------------------
module scan_scheduler #(
   parameter int SCAN_RATE = 32,
   parameter int NUM_ROWS  = 64,
   parameter int THETA_RES = 8,
   parameter int FETCH_LAT = 1
) (
   input  logic                           clk_in,
   input  logic                           rst_n_in,
   input  logic [THETA_RES-1:0]           theta_in,
   input  logic                           theta_valid_in,
   input  logic [SCAN_RATE-1:0]           col_mask_in,
   output logic [$clog2(SCAN_RATE)-1:0]   col_num1_out,
   output logic [$clog2(SCAN_RATE):0]     col_num2_out,
   input  logic [2*NUM_ROWS-1:0]          columns_in,
   output logic [2*NUM_ROWS-1:0]          columns_out,
   output logic [$clog2(SCAN_RATE)-1:0]   col_idx_out,
   output logic [THETA_RES-1:0]           theta_out,
   output logic                           valid_out,
   input  logic                           ready_in,
   output logic                           busy_out,
   output logic                           frame_done_out,
   output logic                           overrun_out
);

   localparam int IDX_W = $clog2(SCAN_RATE);
   localparam int CNT_W = $clog2(FETCH_LAT + 1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ISSUE   = 2'd1;
   localparam logic [1:0] WAIT    = 2'd2;
   localparam logic [1:0] PRESENT = 2'd3;

   logic [1:0]           state;
   logic [SCAN_RATE-1:0] work_mask;
   logic [CNT_W-1:0]     wait_cnt;

   logic [SCAN_RATE-1:0] new_mask;
   logic [SCAN_RATE-1:0] rem_mask;
   logic [IDX_W-1:0]     start_idx;
   logic [IDX_W-1:0]     next_idx;
   logic                 handshake;
   logic                 final_hs;

   // Lowest set bit of a mask; scanning downwards lets the lowest hit win.
   function automatic logic [IDX_W-1:0] lowest_bit(input logic [SCAN_RATE-1:0] m);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int i = SCAN_RATE - 1; i >= 0; i--) begin
         if (m[i]) r = IDX_W'(i);
      end
      return r;
   endfunction

   // Address pair for an index; the second address carries the extra bit so
   // it never wraps back into the first half of the frame buffer.
   function automatic logic [IDX_W:0] upper_addr(input logic [IDX_W-1:0] idx);
      return {1'b0, idx} + (IDX_W + 1)'(SCAN_RATE);
   endfunction

`ifdef SCANLINE_SKIP_EN
   assign new_mask = col_mask_in;
`else
   logic unused_mask;
   assign unused_mask = ^col_mask_in;
   assign new_mask    = '1;
`endif

   // The working mask still contains the column currently on the addresses,
   // so removing it on acceptance yields the columns left in this slice.
   // valid_out is only ever high in PRESENT, so the handshake implies PRESENT.
   always_comb begin
      handshake = valid_out && ready_in;
      rem_mask  = work_mask & ~(SCAN_RATE'(1) << col_num1_out);
      final_hs  = handshake && (rem_mask == '0);
      start_idx = lowest_bit(new_mask);
      next_idx  = lowest_bit(rem_mask);
   end

   assign busy_out = (state != IDLE);

   // Main sequencer. A theta strobe overrides whatever the sequencer was
   // doing: the slice in flight is abandoned (reported as an overrun unless
   // the strobe lands exactly on the final acceptance) and the new slice is
   // started exactly as from IDLE. Addresses are registered on the way into
   // ISSUE so they are already on the bus during the ISSUE cycle.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state          <= IDLE;
         work_mask      <= '0;
         wait_cnt       <= '0;
         col_num1_out   <= '0;
         col_num2_out   <= '0;
         columns_out    <= '0;
         col_idx_out    <= '0;
         theta_out      <= '0;
         valid_out      <= 1'b0;
         frame_done_out <= 1'b0;
         overrun_out    <= 1'b0;
      end else begin
         frame_done_out <= 1'b0;
         overrun_out    <= 1'b0;
         if (theta_valid_in) begin
            if ((state != IDLE) && !final_hs) overrun_out <= 1'b1;
            if (final_hs) frame_done_out <= 1'b1;
            valid_out <= 1'b0;
            theta_out <= theta_in;
            work_mask <= new_mask;
            if (new_mask == '0) begin
               frame_done_out <= 1'b1;
               state          <= IDLE;
            end else begin
               col_num1_out <= start_idx;
               col_num2_out <= upper_addr(start_idx);
               state        <= ISSUE;
            end
         end else begin
            case (state)
               ISSUE: begin
                  wait_cnt <= CNT_W'(FETCH_LAT);
                  state    <= WAIT;
               end
               WAIT: begin
                  wait_cnt <= wait_cnt - CNT_W'(1);
                  if (wait_cnt == CNT_W'(1)) begin
                     columns_out <= columns_in;
                     col_idx_out <= col_num1_out;
                     valid_out   <= 1'b1;
                     state       <= PRESENT;
                  end
               end
               PRESENT: begin
                  if (handshake) begin
                     valid_out <= 1'b0;
                     work_mask <= rem_mask;
                     if (rem_mask == '0) begin
                        frame_done_out <= 1'b1;
                        state          <= IDLE;
                     end else begin
                        col_num1_out <= next_idx;
                        col_num2_out <= upper_addr(next_idx);
                        state        <= ISSUE;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_scan_scheduler.sv
// ---------------------------------------------------------------------------
// tb_scan_scheduler
//
// Purpose:
//   Self-checking bench for scan_scheduler. A slice-level reference model
//   (a queue of column indices still to be shown plus a fetch countdown)
//   predicts every output each cycle; a behavioural frame buffer returns
//   address-dependent data one cycle after the address is driven.
//   Follows SCANLINE_SKIP_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_scan_scheduler;

   localparam int SCAN_RATE = 32;
   localparam int NUM_ROWS  = 64;
   localparam int THETA_RES = 8;
   localparam int FETCH_LAT = 1;

   logic                 clk_in;
   logic                 rst_n_in;
   logic [7:0]           theta_in;
   logic                 theta_valid_in;
   logic [31:0]          col_mask_in;
   logic [4:0]           col_num1_out;
   logic [5:0]           col_num2_out;
   logic [127:0]         columns_in;
   logic [127:0]         columns_out;
   logic [4:0]           col_idx_out;
   logic [7:0]           theta_out;
   logic                 valid_out;
   logic                 ready_in;
   logic                 busy_out;
   logic                 frame_done_out;
   logic                 overrun_out;

   scan_scheduler #(
      .SCAN_RATE (SCAN_RATE),
      .NUM_ROWS  (NUM_ROWS),
      .THETA_RES (THETA_RES),
      .FETCH_LAT (FETCH_LAT)
   ) dut (
      .clk_in         (clk_in),
      .rst_n_in       (rst_n_in),
      .theta_in       (theta_in),
      .theta_valid_in (theta_valid_in),
      .col_mask_in    (col_mask_in),
      .col_num1_out   (col_num1_out),
      .col_num2_out   (col_num2_out),
      .columns_in     (columns_in),
      .columns_out    (columns_out),
      .col_idx_out    (col_idx_out),
      .theta_out      (theta_out),
      .valid_out      (valid_out),
      .ready_in       (ready_in),
      .busy_out       (busy_out),
      .frame_done_out (frame_done_out),
      .overrun_out    (overrun_out)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   int compares   = 0;
   int mismatches = 0;
   int dones_seen = 0;
   int valids_seen = 0;
   int last_a1 = 0;
   int last_a2 = 0;

   // Reference model state: indices still to present (head = current one).
   int         q[$];
   bit         m_active;
   bit         m_valid;
   int         m_cd;
   logic [4:0]   e_a1;
   logic [5:0]   e_a2;
   logic [127:0] e_cols;
   logic [4:0]   e_idx;
   logic [7:0]   e_theta;
   bit         e_done;
   bit         e_ovr;

   // Frame-buffer contents: a distinct word for every address pair.
   function automatic logic [127:0] fb(input int a1, input int a2);
      return {32'hC0DE_0000 | a1, a2 * 32'h9E37_79B9, ~a1, (a1 ^ a2) << 3};
   endfunction

   // Does index i take part in a slice started with mask mk?
   function automatic bit in_slice(input logic [31:0] mk, input int i);
`ifdef SCANLINE_SKIP_EN
      return mk[i];
`else
      return (i >= 0);
`endif
   endfunction

   function automatic int slice_count(input logic [31:0] mk);
      int n;
      n = 0;
      for (int i = 0; i < SCAN_RATE; i++) if (in_slice(mk, i)) n++;
      return n;
   endfunction

   task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] want);
      compares++;
      if (got !== want) begin
         mismatches++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic modelReset();
      q.delete();
      m_active = 0;
      m_valid  = 0;
      m_cd     = 0;
      e_a1 = '0; e_a2 = '0; e_cols = '0; e_idx = '0; e_theta = '0;
      e_done = 0; e_ovr = 0;
   endtask

   // Advance the model across one clock edge using the inputs of the cycle
   // that edge ends. Fetch of a column takes FETCH_LAT+1 cycles (issue plus
   // latency) before it is presented.
   task automatic modelStep(input bit tv, input logic [7:0] th, input logic [31:0] mk, input bit rdy);
      bit hs;
      bit fin;
      hs  = m_valid && rdy;
      fin = 0;
      e_done = 0;
      e_ovr  = 0;
      if (hs) begin
         void'(q.pop_front());
         fin = (q.size() == 0);
      end
      if (tv) begin
         if (m_active && !(hs && fin)) e_ovr = 1;
         if (hs && fin) e_done = 1;
         e_theta = th;
         m_valid = 0;
         q.delete();
         for (int i = 0; i < SCAN_RATE; i++) if (in_slice(mk, i)) q.push_back(i);
         if (q.size() == 0) begin
            e_done   = 1;
            m_active = 0;
         end else begin
            m_active = 1;
            m_cd     = FETCH_LAT + 1;
            e_a1     = 5'(q[0]);
            e_a2     = 6'(q[0] + SCAN_RATE);
         end
      end else if (m_active) begin
         if (m_valid) begin
            if (hs) begin
               m_valid = 0;
               if (fin) begin
                  e_done   = 1;
                  m_active = 0;
               end else begin
                  m_cd = FETCH_LAT + 1;
                  e_a1 = 5'(q[0]);
                  e_a2 = 6'(q[0] + SCAN_RATE);
               end
            end
         end else begin
            m_cd--;
            if (m_cd == 0) begin
               m_valid = 1;
               e_idx   = 5'(q[0]);
               e_cols  = fb(q[0], q[0] + SCAN_RATE);
            end
         end
      end
   endtask

   task automatic compareAll();
      checkOutput("valid",   128'(valid_out),      128'(m_valid));
      checkOutput("busy",    128'(busy_out),       128'(m_active));
      checkOutput("done",    128'(frame_done_out), 128'(e_done));
      checkOutput("overrun", 128'(overrun_out),    128'(e_ovr));
      checkOutput("addr1",   128'(col_num1_out),   128'(e_a1));
      checkOutput("addr2",   128'(col_num2_out),   128'(e_a2));
      checkOutput("col_idx", 128'(col_idx_out),    128'(e_idx));
      checkOutput("columns", columns_out,          e_cols);
      checkOutput("theta",   128'(theta_out),      128'(e_theta));
   endtask

   // Drive one cycle of inputs, step across the clock edge, update the
   // frame buffer with the address seen during the previous cycle, then
   // compare everything against the model.
   task automatic applyStimulus(input bit tv, input logic [7:0] th, input logic [31:0] mk, input bit rdy);
      theta_valid_in = tv;
      theta_in       = th;
      col_mask_in    = mk;
      ready_in       = rdy;
      @(posedge clk_in);
      #1;
      modelStep(tv, th, mk, rdy);
      columns_in = fb(last_a1, last_a2);
      last_a1 = int'(col_num1_out);
      last_a2 = int'(col_num2_out);
      if (frame_done_out === 1'b1) dones_seen++;
      if (valid_out === 1'b1) valids_seen++;
      compareAll();
   endtask

   task automatic idle(input bit rdy);
      applyStimulus(1'b0, 8'($urandom), $urandom, rdy);
   endtask

   task automatic runUntilValid(input bit rdy);
      int n;
      n = 0;
      while (valid_out !== 1'b1 && n < 50) begin
         idle(rdy);
         n++;
      end
      checkOutput("valid_wait", 128'(valid_out), 128'(1));
   endtask

   task automatic settle();
      int n;
      n = 0;
      while (busy_out !== 1'b0 && n < 200) begin
         idle(1'b1);
         n++;
      end
      checkOutput("settle", 128'(busy_out), 128'(0));
   endtask

   initial begin
      rst_n_in       = 1'b0;
      theta_in       = '0;
      theta_valid_in = 1'b0;
      col_mask_in    = '0;
      ready_in       = 1'b0;
      columns_in     = '0;
      modelReset();
      @(posedge clk_in);
      @(posedge clk_in);
      #1;
      compareAll();
      rst_n_in = 1'b1;

      // Single enabled column: addresses on cycle 1, data on cycle 3.
      applyStimulus(1'b1, 8'h10, 32'h0000_0001, 1'b1);
      checkOutput("t1_addr1", 128'(col_num1_out), 128'(0));
      checkOutput("t1_addr2", 128'(col_num2_out), 128'(32));
      idle(1'b1);
      idle(1'b1);
      checkOutput("t1_valid", 128'(valid_out), 128'(1));
      checkOutput("t1_cols",  columns_out, fb(0, 32));
      settle();

      // Sparse mask with one frame_done per slice.
      dones_seen = 0;
      applyStimulus(1'b1, 8'h33, 32'h8000_0005, 1'b1);
      for (int i = 0; i < 110; i++) idle(1'b1);
      checkOutput("t2_done_count", 128'(dones_seen), 128'(1));

      // Back-pressure: output held through five stalled cycles.
      applyStimulus(1'b1, 8'h44, 32'h0000_0003, 1'b0);
      runUntilValid(1'b0);
      for (int i = 0; i < 5; i++) begin
         idle(1'b0);
         checkOutput("t3_stall_valid", 128'(valid_out), 128'(1));
         checkOutput("t3_stall_idx",   128'(col_idx_out), 128'(0));
      end
      idle(1'b1);
      runUntilValid(1'b1);
      checkOutput("t3_next_idx", 128'(col_idx_out), 128'(1));
      settle();

      // New strobe during the fetch of index 1 aborts the slice.
      dones_seen = 0;
      applyStimulus(1'b1, 8'h55, 32'h0000_000F, 1'b1);
      for (int i = 0; i < 4; i++) idle(1'b1);
      applyStimulus(1'b1, 8'h20, 32'h0000_0001, 1'b1);
      checkOutput("t4_overrun", 128'(overrun_out), 128'(1));
      checkOutput("t4_theta",   128'(theta_out),   128'(8'h20));
      runUntilValid(1'b1);
      checkOutput("t4_idx", 128'(col_idx_out), 128'(0));
      for (int i = 0; i < 110; i++) idle(1'b1);
      checkOutput("t4_done_count", 128'(dones_seen), 128'(1));

      // Empty mask.
      valids_seen = 0;
      applyStimulus(1'b1, 8'h66, 32'h0, 1'b1);
      for (int i = 0; i < 110; i++) idle(1'b1);
      checkOutput("t5_presented", 128'(valids_seen), 128'(slice_count(32'h0)));

      // Asynchronous reset while a column is being presented.
      settle();
      applyStimulus(1'b1, 8'h77, 32'h0000_0003, 1'b0);
      runUntilValid(1'b0);
      #2;
      rst_n_in = 1'b0;
      #1;
      checkOutput("rst_valid",   128'(valid_out),      128'(0));
      checkOutput("rst_busy",    128'(busy_out),       128'(0));
      checkOutput("rst_done",    128'(frame_done_out), 128'(0));
      checkOutput("rst_overrun", 128'(overrun_out),    128'(0));
      checkOutput("rst_addr1",   128'(col_num1_out),   128'(0));
      checkOutput("rst_addr2",   128'(col_num2_out),   128'(0));
      checkOutput("rst_idx",     128'(col_idx_out),    128'(0));
      checkOutput("rst_cols",    columns_out,          128'(0));
      checkOutput("rst_theta",   128'(theta_out),      128'(0));
      modelReset();
      theta_valid_in = 1'b0;
      @(posedge clk_in);
      #1;
      columns_in = fb(0, 0);
      last_a1 = 0;
      last_a2 = 0;
      compareAll();
      rst_n_in = 1'b1;
      for (int i = 0; i < 5; i++) idle(1'b1);

      // Randomized traffic: strobes, masks and back-pressure.
      for (int c = 0; c < 3000; c++) begin
         bit          tv;
         bit          rdy;
         logic [31:0] mk;
         tv = ($urandom_range(0, 59) == 0);
         case ($urandom_range(0, 3))
            0:       mk = 32'h0;
            1:       mk = 32'h1 << $urandom_range(0, 31);
            2:       mk = $urandom & $urandom;
            default: mk = $urandom;
         endcase
         rdy = ($urandom_range(0, 9) < 7);
         applyStimulus(tv, 8'($urandom), mk, rdy);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
      $finish;
   end

endmodule
